// File: rtl/cmp_unit_arbiter.sv
// Arbitrates the shared lui/slt compare unit between EX (priority) and ID branch compares.
// Grants are combinational; results and owner state are registered with 1-cycle latency.
module cmp_unit_arbiter #(
    parameter int unsigned STARVE_MAX = 2,
    parameter int unsigned CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_req,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic [1:0]  ex_aluc,
    input  logic        br_req,
    input  logic [31:0] br_a,
    input  logic [31:0] br_b,
    input  logic        br_signed,
    input  logic        br_flush,
    output logic [31:0] cu_a,
    output logic [31:0] cu_b,
    output logic [1:0]  cu_aluc,
    input  logic [31:0] cu_r,
    input  logic        cu_eq,
    input  logic        cu_lt,
    output logic        ex_gnt,
    output logic        br_gnt,
    output logic        ex_stall,
    output logic        br_stall,
    output logic        ex_valid,
    output logic [31:0] ex_r,
    output logic        br_valid,
    output logic        br_eq,
    output logic        br_lt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EX   = 2'b01,
        S_BR   = 2'b10
    } owner_t;

    owner_t             state;
    logic [CNT_W-1:0]   starve_cnt;
    logic               br_live;
    logic               starved;

    // br_lt is taken from the slt result bit so it honours br_signed; cu_lt is unsigned-only.
    logic unused_cu_lt;
    assign unused_cu_lt = cu_lt;

    always_comb begin
        br_live  = br_req & ~br_flush;
        starved  = (starve_cnt == CNT_W'(STARVE_MAX));
        br_gnt   = br_live & (~ex_req | starved);
        ex_gnt   = ex_req & ~br_gnt;
        ex_stall = ex_req & ~ex_gnt;
        br_stall = br_req & ~br_gnt & ~br_flush;
    end

    always_comb begin
        cu_a    = '0;
        cu_b    = '0;
        cu_aluc = 2'b00;
        if (ex_gnt) begin
            cu_a    = ex_a;
            cu_b    = ex_b;
            cu_aluc = ex_aluc;
        end else if (br_gnt) begin
            cu_a    = br_a;
            cu_b    = br_b;
            cu_aluc = {1'b1, br_signed};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            ex_r       <= '0;
            br_eq      <= 1'b0;
            br_lt      <= 1'b0;
        end else begin
            if (br_gnt)
                state <= S_BR;
            else if (ex_gnt)
                state <= S_EX;
            else
                state <= S_IDLE;

            if (!br_live || br_gnt)
                starve_cnt <= '0;
            else if (ex_gnt && !starved)
                starve_cnt <= starve_cnt + CNT_W'(1);

            if (ex_gnt)
                ex_r <= cu_r;
            if (br_gnt) begin
                br_eq <= cu_eq;
                br_lt <= cu_r[0];
            end
        end
    end

    assign ex_valid = (state == S_EX);
    assign br_valid = (state == S_BR);

endmodule

// File: tb/tb_cmp_unit_arbiter.sv
// Self-checking bench for cmp_unit_arbiter: directed table, multi-cycle corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_cmp_unit_arbiter;

    localparam int unsigned STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_req;
    logic [31:0] ex_a, ex_b;
    logic [1:0]  ex_aluc;
    logic        br_req;
    logic [31:0] br_a, br_b;
    logic        br_signed, br_flush;
    logic [31:0] cu_a, cu_b;
    logic [1:0]  cu_aluc;
    logic [31:0] cu_r;
    logic        cu_eq, cu_lt;
    logic        ex_gnt, br_gnt, ex_stall, br_stall;
    logic        ex_valid, br_valid, br_eq, br_lt;
    logic [31:0] ex_r;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int          m_wait;
    logic        m_ex_v, m_br_v, m_br_eq, m_br_lt;
    logic [31:0] m_ex_r;
    logic        g_ex, g_br;

    always #5 clk = ~clk;

    cmp_unit_arbiter #(.STARVE_MAX(2), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_req(ex_req), .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
        .br_req(br_req), .br_a(br_a), .br_b(br_b), .br_signed(br_signed), .br_flush(br_flush),
        .cu_a(cu_a), .cu_b(cu_b), .cu_aluc(cu_aluc),
        .cu_r(cu_r), .cu_eq(cu_eq), .cu_lt(cu_lt),
        .ex_gnt(ex_gnt), .br_gnt(br_gnt), .ex_stall(ex_stall), .br_stall(br_stall),
        .ex_valid(ex_valid), .ex_r(ex_r),
        .br_valid(br_valid), .br_eq(br_eq), .br_lt(br_lt)
    );

    function automatic logic [31:0] unit_r(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] aluc);
        if (!aluc[1])
            return {b[15:0], 16'h0000};
        else if (aluc[0])
            return {31'b0, ($signed(a) < $signed(b))};
        else
            return {31'b0, (a < b)};
    endfunction

    // Shared LuiSlt unit
    always_comb begin
        cu_r  = unit_r(cu_a, cu_b, cu_aluc);
        cu_eq = (cu_a == cu_b);
        cu_lt = (cu_a < cu_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wait  = 0;
        m_ex_v  = 1'b0;
        m_ex_r  = '0;
        m_br_v  = 1'b0;
        m_br_eq = 1'b0;
        m_br_lt = 1'b0;
    endtask

    task automatic idle_inputs();
        ex_req = 1'b0; ex_a = '0; ex_b = '0; ex_aluc = 2'b00;
        br_req = 1'b0; br_a = '0; br_b = '0; br_signed = 1'b0; br_flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_br_valid", br_valid, 1'b0);
        chk("rst_ex_r", ex_r, 32'h0);
        chk("rst_br_eq", br_eq, 1'b0);
        chk("rst_br_lt", br_lt, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs, advance, check registered outputs.
    task automatic cycle();
        logic live, bw, ew;
        logic [31:0] ea, eb;
        logic [1:0]  ec;
        #1;
        live = br_req & ~br_flush;
        bw   = live && (!ex_req || m_wait >= int'(STARVE_MAX));
        ew   = ex_req && !bw;
        ea = '0; eb = '0; ec = 2'b00;
        if (ew) begin ea = ex_a; eb = ex_b; ec = ex_aluc; end
        else if (bw) begin ea = br_a; eb = br_b; ec = {1'b1, br_signed}; end
        g_ex = ex_gnt;
        g_br = br_gnt;
        chk("ex_gnt", ex_gnt, ew);
        chk("br_gnt", br_gnt, bw);
        chk("ex_stall", ex_stall, ex_req & ~ew);
        chk("br_stall", br_stall, live & ~bw);
        chk("cu_a", cu_a, ea);
        chk("cu_b", cu_b, eb);
        chk("cu_aluc", cu_aluc, ec);
        @(posedge clk);
        if (live && !bw)
            m_wait = (m_wait + 1 > int'(STARVE_MAX)) ? int'(STARVE_MAX) : m_wait + 1;
        else
            m_wait = 0;
        m_ex_v = ew;
        m_br_v = bw;
        if (ew) m_ex_r = unit_r(ex_a, ex_b, ex_aluc);
        if (bw) begin
            m_br_eq = (br_a == br_b);
            m_br_lt = br_signed ? ($signed(br_a) < $signed(br_b)) : (br_a < br_b);
        end
        #1;
        chk("ex_valid", ex_valid, m_ex_v);
        chk("ex_r", ex_r, m_ex_r);
        chk("br_valid", br_valid, m_br_v);
        chk("br_eq", br_eq, m_br_eq);
        chk("br_lt", br_lt, m_br_lt);
    endtask

    typedef struct {
        logic        ex_req;
        logic [31:0] ex_a, ex_b;
        logic [1:0]  ex_aluc;
        logic        br_req;
        logic [31:0] br_a, br_b;
        logic        br_signed, br_flush;
        logic        e_ex_gnt, e_br_gnt, e_ex_valid;
        logic [31:0] e_ex_r;
        logic        e_br_valid, e_br_eq, e_br_lt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [4:0] pat_ex, pat_br;

        vecs[0] = '{1, 32'd5, 32'd7, 2'b11, 0, 32'h0, 32'h0, 0, 0,
                    1, 0, 1, 32'h1, 0, 0, 0};
        vecs[1] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h80000000, 32'h80000000, 1, 0,
                    0, 1, 0, 32'h1, 1, 1, 0};
        vecs[2] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'hFFFFFFFF, 32'h1, 1, 0,
                    0, 1, 0, 32'h1, 1, 0, 1};
        vecs[3] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'hFFFFFFFF, 32'h1, 0, 0,
                    0, 1, 0, 32'h1, 1, 0, 0};
        vecs[4] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h5, 32'h5, 1, 1,
                    0, 0, 0, 32'h1, 0, 0, 0};
        vecs[5] = '{1, 32'hDEAD, 32'h1234, 2'b00, 0, 32'h0, 32'h0, 0, 0,
                    1, 0, 1, 32'h12340000, 0, 0, 0};
        vecs[6] = '{1, 32'hFFFFFFFF, 32'h1, 2'b10, 0, 32'h0, 32'h0, 0, 0,
                    1, 0, 1, 32'h0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            ex_req = vecs[i].ex_req; ex_a = vecs[i].ex_a; ex_b = vecs[i].ex_b;
            ex_aluc = vecs[i].ex_aluc;
            br_req = vecs[i].br_req; br_a = vecs[i].br_a; br_b = vecs[i].br_b;
            br_signed = vecs[i].br_signed; br_flush = vecs[i].br_flush;
            cycle();
            chk($sformatf("vec%0d_ex_gnt", i), g_ex, vecs[i].e_ex_gnt);
            chk($sformatf("vec%0d_br_gnt", i), g_br, vecs[i].e_br_gnt);
            chk($sformatf("vec%0d_ex_valid", i), ex_valid, vecs[i].e_ex_valid);
            chk($sformatf("vec%0d_ex_r", i), ex_r, vecs[i].e_ex_r);
            chk($sformatf("vec%0d_br_valid", i), br_valid, vecs[i].e_br_valid);
            chk($sformatf("vec%0d_br_eq", i), br_eq, vecs[i].e_br_eq);
            chk($sformatf("vec%0d_br_lt", i), br_lt, vecs[i].e_br_lt);
        end

        // Contention with both held: EX, EX, BR, EX
        do_reset();
        ex_req = 1; ex_a = 32'd3; ex_b = 32'd2; ex_aluc = 2'b11;
        br_req = 1; br_a = 32'd1; br_b = 32'd1; br_signed = 0;
        pat_ex = 5'b01011;
        pat_br = 5'b00100;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("cont%0d_ex_gnt", i), g_ex, pat_ex[i]);
            chk($sformatf("cont%0d_br_gnt", i), g_br, pat_br[i]);
        end

        // Flush clears the starvation count: EX, EX(flush), EX, EX, BR
        do_reset();
        ex_req = 1; ex_a = 32'd9; ex_b = 32'd4; ex_aluc = 2'b10;
        br_req = 1; br_a = 32'h7; br_b = 32'h8; br_signed = 1;
        pat_ex = 5'b01111;
        pat_br = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            br_flush = (i == 1);
            cycle();
            chk($sformatf("flush%0d_ex_gnt", i), g_ex, pat_ex[i]);
            chk($sformatf("flush%0d_br_gnt", i), g_br, pat_br[i]);
        end
        br_flush = 0;

        // Reset right after a capture drops the result and does not replay it
        do_reset();
        ex_req = 1; ex_a = 32'd5; ex_b = 32'd7; ex_aluc = 2'b11;
        cycle();
        chk("midrst_pre_valid", ex_valid, 1'b1);
        ex_req = 0;
        rst_n = 0;
        model_clear();
        #1;
        chk("midrst_ex_valid", ex_valid, 1'b0);
        chk("midrst_ex_r", ex_r, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle();
        chk("midrst_no_replay", ex_valid, 1'b0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ex_req    = ($urandom_range(0, 9) < 7);
            ex_a      = $urandom;
            ex_b      = ($urandom_range(0, 3) == 0) ? ex_a : $urandom;
            ex_aluc   = 2'($urandom_range(0, 3));
            br_req    = ($urandom_range(0, 9) < 6);
            br_a      = $urandom;
            br_b      = ($urandom_range(0, 3) == 0) ? br_a : $urandom;
            br_signed = 1'($urandom_range(0, 1));
            br_flush  = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
